// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/trap select, stall, interrupt entry and EPC; PCU_REDIRECT_CNT_EN adds redirect_cnt
module pc_unit #(
  parameter int PC_W = 16,
  parameter int SRC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] INT_VECTOR = 16'h0005
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SRC_W-1:0] pc_src,
  input  logic             zero,
  input  logic             cond_inv,
  input  logic [PC_W-1:0]  pc_branch8,
  input  logic [PC_W-1:0]  pc_branch11,
  input  logic [PC_W-1:0]  pc_jump,
  input  logic             stall,
  input  logic             int_req,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic [PC_W-1:0]  epc,
  output logic             in_handler,
  output logic             int_ack,
  output logic             redirect
`ifdef PCU_REDIRECT_CNT_EN
  ,
  output logic [15:0]      redirect_cnt
`endif
);
  localparam logic [SRC_W-1:0] SRC_BR8 = SRC_W'(8'h02);
  localparam logic [SRC_W-1:0] SRC_BR11 = SRC_W'(8'h03);
  localparam logic [SRC_W-1:0] SRC_JUMP = SRC_W'(8'h04);
  localparam logic [SRC_W-1:0] SRC_INT = SRC_W'(8'h28);
  localparam logic [SRC_W-1:0] SRC_ERET = SRC_W'(8'h29);
  typedef enum logic [1:0] {S_RUN, S_ENTRY, S_SERVICE} state_t;
  state_t r_state, w_nxt_state;
  logic [PC_W-1:0] r_pc, r_epc, w_nxt_pc, w_nxt_epc, w_pc_plus1, w_target;
  logic r_redirect, r_int_ack, w_nxt_redirect, w_nxt_ack, w_taken, w_seq;
  assign w_pc_plus1 = r_pc + PC_W'(1);
  assign w_taken = zero ^ cond_inv;
  // next-PC select, interrupt/trap entry and handler exit; stall freezes everything
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc = r_pc;
    w_nxt_epc = r_epc;
    w_nxt_redirect = r_redirect;
    w_nxt_ack = 1'b0;
    w_target = w_pc_plus1;
    w_seq = 1'b1;
    case (pc_src)
      SRC_BR8: if (w_taken) begin w_target = pc_branch8; w_seq = 1'b0; end
      SRC_BR11: if (w_taken) begin w_target = pc_branch11; w_seq = 1'b0; end
      SRC_JUMP: begin w_target = pc_jump; w_seq = 1'b0; end
      SRC_INT: if (r_state == S_RUN) begin w_target = INT_VECTOR; w_seq = 1'b0; end
      SRC_ERET: if (r_state == S_SERVICE) begin w_target = r_epc; w_seq = 1'b0; end
      default: ;
    endcase
    if (!stall) begin
      w_nxt_pc = w_target;
      w_nxt_redirect = !w_seq;
      if (r_state == S_RUN && int_req) begin
        w_nxt_epc = (pc_src == SRC_INT) ? w_pc_plus1 : w_target;
        w_nxt_pc = INT_VECTOR;
        w_nxt_redirect = 1'b1;
        w_nxt_ack = 1'b1;
        w_nxt_state = S_ENTRY;
      end else if (r_state == S_RUN && pc_src == SRC_INT) begin
        w_nxt_epc = w_pc_plus1;
        w_nxt_state = S_ENTRY;
      end else if (r_state == S_ENTRY) begin
        w_nxt_state = S_SERVICE;
      end else if (r_state == S_SERVICE && pc_src == SRC_ERET) begin
        w_nxt_state = S_RUN;
      end
    end
  end
  // state and PC registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_pc <= RESET_PC;
      r_epc <= '0;
      r_redirect <= 1'b0;
      r_int_ack <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc <= w_nxt_pc;
      r_epc <= w_nxt_epc;
      r_redirect <= w_nxt_redirect;
      r_int_ack <= w_nxt_ack;
    end
  end
`ifdef PCU_REDIRECT_CNT_EN
  logic [15:0] r_redirect_cnt;
  // counts cycles spent with redirect asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_redirect_cnt <= '0;
    else r_redirect_cnt <= r_redirect_cnt + {15'd0, r_redirect};
  end
  assign redirect_cnt = r_redirect_cnt;
`endif
  assign pc = r_pc;
  assign pc_plus1 = w_pc_plus1;
  assign epc = r_epc;
  assign in_handler = (r_state != S_RUN);
  assign int_ack = r_int_ack;
  assign redirect = r_redirect;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit
module tb_pc_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] pc_src = 8'h01;
  logic zero = 1'b0, cond_inv = 1'b0, stall = 1'b0, int_req = 1'b0;
  logic [15:0] pc_branch8 = '0, pc_branch11 = '0, pc_jump = '0;
  logic [15:0] pc, pc_plus1, epc;
  logic in_handler, int_ack, redirect;
`ifdef PCU_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif
  int n_vec = 0, n_err = 0;
  pc_unit dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .zero(zero), .cond_inv(cond_inv),
    .pc_branch8(pc_branch8), .pc_branch11(pc_branch11), .pc_jump(pc_jump),
    .stall(stall), .int_req(int_req), .pc(pc), .pc_plus1(pc_plus1), .epc(epc),
    .in_handler(in_handler), .int_ack(int_ack), .redirect(redirect)
`ifdef PCU_REDIRECT_CNT_EN
    , .redirect_cnt(redirect_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic jump_to(input logic [15:0] a);
    pc_src = 8'h04;
    pc_jump = a;
    step();
    pc_src = 8'h01;
  endtask
  initial begin
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_hnd", in_handler, 1'b0);
    chk("rst_ack", int_ack, 1'b0);
    chk("rst_redir", redirect, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc, 32'(i));
      chk("seq_redir", redirect, 1'b0);
    end
    chk("plus1", pc_plus1, 16'h0005);
    jump_to(16'h0010);
    chk("jmp_pc", pc, 16'h0010);
    chk("jmp_redir", redirect, 1'b1);
    pc_src = 8'h02; pc_branch8 = 16'h0020; zero = 1'b1; cond_inv = 1'b0;
    step();
    chk("br8_taken_pc", pc, 16'h0020);
    chk("br8_taken_redir", redirect, 1'b1);
    jump_to(16'h0010);
    pc_src = 8'h02; cond_inv = 1'b1;
    step();
    chk("br8_nt_pc", pc, 16'h0011);
    chk("br8_nt_redir", redirect, 1'b0);
    pc_src = 8'h03; pc_branch11 = 16'h0300; zero = 1'b0; cond_inv = 1'b1;
    step();
    chk("br11_bnez_pc", pc, 16'h0300);
    pc_src = 8'h02; pc_branch8 = 16'h0301; zero = 1'b1; cond_inv = 1'b0;
    step();
    chk("br_plus1_pc", pc, 16'h0301);
    chk("br_plus1_redir", redirect, 1'b1);
    pc_src = 8'h77;
    step();
    chk("bad_code_pc", pc, 16'h0302);
    chk("bad_code_redir", redirect, 1'b0);
    jump_to(16'h0040);
    pc_src = 8'h04; pc_jump = 16'h1234; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 16'h0040);
      chk("stall_redir", redirect, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", pc, 16'h1234);
    jump_to(16'h0030);
    int_req = 1'b1;
    step();
    chk("irq_pc", pc, 16'h0005);
    chk("irq_epc", epc, 16'h0031);
    chk("irq_ack", int_ack, 1'b1);
    chk("irq_hnd", in_handler, 1'b1);
    step();
    chk("svc_pc", pc, 16'h0006);
    chk("svc_ack", int_ack, 1'b0);
    step();
    chk("svc2_pc", pc, 16'h0007);
    chk("svc2_hnd", in_handler, 1'b1);
    chk("svc2_epc", epc, 16'h0031);
    int_req = 1'b0; pc_src = 8'h29;
    step();
    chk("eret_pc", pc, 16'h0031);
    chk("eret_hnd", in_handler, 1'b0);
    chk("eret_redir", redirect, 1'b1);
    step();
    chk("eret_run_pc", pc, 16'h0032);
    chk("eret_run_redir", redirect, 1'b0);
    jump_to(16'h0050);
    pc_src = 8'h28; int_req = 1'b1;
    step();
    chk("int_trap_ack", int_ack, 1'b1);
    chk("int_trap_epc", epc, 16'h0051);
    chk("int_trap_pc", pc, 16'h0005);
    int_req = 1'b0; pc_src = 8'h01;
    step();
    pc_src = 8'h28;
    step();
    chk("svc_trap_pc", pc, 16'h0007);
    chk("svc_trap_epc", epc, 16'h0051);
    pc_src = 8'h29;
    step();
    chk("eret2_pc", pc, 16'h0051);
    pc_src = 8'h28;
    step();
    chk("trap_pc", pc, 16'h0005);
    chk("trap_epc", epc, 16'h0052);
    chk("trap_ack", int_ack, 1'b0);
    chk("trap_hnd", in_handler, 1'b1);
    pc_src = 8'h01;
    step();
    pc_src = 8'h29;
    step();
    chk("eret3_pc", pc, 16'h0052);
    chk("eret3_hnd", in_handler, 1'b0);
    pc_src = 8'h01; stall = 1'b1; int_req = 1'b1;
    step();
    chk("stall_irq_pc", pc, 16'h0052);
    chk("stall_irq_ack", int_ack, 1'b0);
    chk("stall_irq_hnd", in_handler, 1'b0);
    stall = 1'b0; int_req = 1'b0;
    jump_to(16'hFFFF);
    chk("wrap_plus1", pc_plus1, 16'h0000);
    step();
    chk("wrap_pc", pc, 16'h0000);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    step();
    chk("pre_rst_hnd", in_handler, 1'b1);
    chk("pre_rst_epc", epc, 16'h0001);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_hnd", in_handler, 1'b0);
    chk("arst_epc", epc, 16'h0000);
    chk("arst_redir", redirect, 1'b0);
    rst = 1'b1;
    step();
    chk("post_rst_pc", pc, 16'h0001);
    chk("post_rst_hnd", in_handler, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the multi-cycle/pipelined CPU.
- Owns the PC register and selects the next PC from these sources: sequential, 8-bit-offset branch, 11-bit-offset branch, register jump, trap vector and exception return.
- Adds stall, flush, external interrupt entry, EPC save/restore and a small interrupt state machine.
- Sits between the control unit and instruction fetch, and replaces the purely combinational PC select.

Parameters:
PC_W, 16, width of PC, branch targets and jump register.
SRC_W, 8, width of pc_src control code.
RESET_PC, 16'h0000, PC value loaded on reset.
INT_VECTOR, 16'h0005, handler entry address for traps and external interrupts.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
pc_src  input  SRC_W  next-PC select: 8'h01 NEXT, 8'h02 BRANCH8, 8'h03 BRANCH11, 8'h04 JUMP, 8'h28 INTJUMP (trap), 8'h29 ERET; any other code = NEXT.
zero  input  1  condition flag from ALU.
cond_inv  input  1  1 = branch taken when zero==0 (BNEZ); 0 = taken when zero==1.
pc_branch8  input  PC_W  precomputed 8-bit-offset target.
pc_branch11  input  PC_W  precomputed 11-bit-offset target.
pc_jump  input  PC_W  register jump target.
stall  input  1  hold PC this cycle.
int_req  input  1  external interrupt request, level, sampled each cycle.
pc  output  PC_W  current PC (registered).
pc_plus1  output  PC_W  pc+1, combinational, wraps modulo 2^PC_W.
epc  output  PC_W  saved return address.
in_handler  output  1  1 while in INT_SERVICE.
int_ack  output  1  one-cycle pulse on interrupt acceptance.
redirect  output  1  registered; 1 in the cycle after pc loaded a non-sequential value (fetch flush).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, epc=0, in_handler=0, int_ack=0, redirect=0.
  - State=RUN.
  - Reset mid-handler abandons the handler with no residue.
- Taken: taken = zero XOR cond_inv.
- Target per code:
  - NEXT: pc+1.
  - BRANCH8: pc_branch8 if taken, else pc+1.
  - BRANCH11: pc_branch11 if taken, else pc+1.
  - JUMP: pc_jump, unconditional.
  - INTJUMP: INT_VECTOR, treated as trap entry.
  - ERET: epc.
- Update: pc updates every clock edge unless stall=1. While stalled, pc, epc, state and redirect hold, int_ack=0, and int_req is ignored.
- redirect=1 the cycle after any load other than pc+1. A taken branch whose target equals pc+1 still sets redirect.
- State machine:
  - RUN:
    - If int_req=1 and not stalled: epc<=computed target (the instruction that would have executed next), pc<=INT_VECTOR, int_ack=1, go ENTRY.
    - Else if pc_src=INTJUMP: epc<=pc+1, pc<=INT_VECTOR, go ENTRY (no int_ack).
    - ERET in RUN behaves as NEXT (illegal, ignored).
  - ENTRY: single cycle, in_handler=1. pc follows pc_src normally. Go SERVICE.
  - SERVICE:
    - in_handler=1; int_req and INTJUMP are masked, and INTJUMP behaves as NEXT.
    - On ERET and not stalled: pc<=epc, go RUN, in_handler=0 from the next cycle.
- Simultaneous events:
  - int_req beats INTJUMP and branches in RUN.
  - stall beats everything.
- Widths: all adds are modulo 2^PC_W, so pc=all-ones gives NEXT=0.

Optional Feature:
- Macro: PCU_REDIRECT_CNT_EN.
- Defined:
  - Adds output redirect_cnt [15:0], reset to 0.
  - Increments (wrapping) on every cycle where redirect=1.
  - Readable for performance debug.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset release with RESET_PC=0: pc_src=NEXT for 4 cycles -> pc 0,1,2,3,4; redirect stays 0.
2. pc=0x0010, pc_src=BRANCH8, pc_branch8=0x0020:
   - zero=1, cond_inv=0 -> pc=0x0020 and redirect=1 next cycle.
   - Repeat with cond_inv=1 -> pc=0x0011 and redirect=0.
3. pc=0x0040, stall=1 for 3 cycles with pc_src=JUMP, pc_jump=0x1234 -> pc stays 0x0040. Stall drop -> pc=0x1234.
4. pc=0x0030, pc_src=NEXT, int_req=1 ->
   - pc=0x0005, epc=0x0031, int_ack pulse, in_handler=1.
   - int_req held during handler -> no re-entry.
   - ERET -> pc=0x0031, in_handler=0.
5. pc=0x0050, pc_src=INTJUMP with int_req=1 same cycle -> int_ack=1, epc=0x0051, pc=0x0005.
6. pc=0xFFFF, NEXT -> pc=0x0000. Assert rst low mid-SERVICE -> pc=RESET_PC, in_handler=0, epc=0 immediately (asynchronous).
